// File: rtl/apb_master_bridge.sv
// Single-outstanding APB4 requester: valid/ready command in, SETUP/ACCESS on APB,
// read data and error status returned on a valid/ready response channel.
module apb_master_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB requester
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [STRB_WIDTH-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  // Terminal count: the abort fires on the edge ending the TIMEOUT_CYCLES-th ACCESS cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                state_q,       state_d;
  logic [CNT_W-1:0]      cnt_q,         cnt_d;
  logic                  cmd_ready_q,   cmd_ready_d;
  logic                  psel_q,        psel_d;
  logic                  penable_q,     penable_d;
  logic                  pwrite_q,      pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q,       pstrb_d;
  logic                  rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic                  rsp_err_q,     rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic timeout_hit;

  assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = cmd_ready_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
          pstrb_d     = cmd_write ? cmd_strb : '0;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          state_d     = SETUP;
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end

      ACCESS: begin
        // pready takes priority over the terminal count
        if (pready) begin
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (timeout_hit) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: directed transfers push expected responses,
// a negedge monitor pops them on each response handshake.
module tb_apb_master_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;

  apb_master_bridge #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_strb   (cmd_strb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
  } rsp_t;

  rsp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // slave behaviour knobs, set by the main sequence well before ACCESS
  int          slv_wait  = 0;
  logic        slv_hang  = 1'b0;
  logic        slv_err   = 1'b0;
  logic [DW-1:0] slv_rdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // APB responder: pready after slv_wait ACCESS cycles; pslverr/prdata junk while not ready
  initial begin : slave
    int   acc_n;
    logic in_acc;
    acc_n   = 0;
    in_acc  = 1'b0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    forever begin
      tick();
      if (psel && penable) begin
        acc_n  = in_acc ? acc_n + 1 : 0;
        in_acc = 1'b1;
      end else begin
        acc_n  = 0;
        in_acc = 1'b0;
      end
      pready  = in_acc && !slv_hang && (acc_n == slv_wait);
      pslverr = pready ? slv_err : 1'b1;
      prdata  = pready ? slv_rdata : 32'hBADC_AFE0;
    end
  end

  // response monitor
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got rdata=0x%0h err=%0b to=%0b expected none",
                   rsp_rdata, rsp_err, rsp_timeout);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata",   64'(rsp_rdata),   64'(e.rdata));
          check("rsp_err",     64'(rsp_err),     64'(e.err));
          check("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
        end
      end
    end
  end

  task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] strb, input int wait_n, input logic hang,
                         input logic [DW-1:0] srd, input logic serr, input int bp,
                         input int exp_n, input logic [DW-1:0] exp_rd, input logic exp_err,
                         input logic exp_to);
    rsp_t e;
    int   n;
    logic hold_bad;
    slv_wait  = wait_n;
    slv_hang  = hang;
    slv_rdata = srd;
    slv_err   = serr;
    rsp_ready = (bp == 0);
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.to    = exp_to;
    exp_q.push_back(e);
    check("idle_ready", 64'(cmd_ready), 64'd1);
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("setup_psel",    64'(psel),      64'd1);
    check("setup_penable", 64'(penable),   64'd0);
    check("setup_ready",   64'(cmd_ready), 64'd0);
    check("paddr",  64'(paddr),  64'(addr));
    check("pwrite", 64'(pwrite), 64'(wr));
    check("pwdata", 64'(pwdata), 64'(wdata));
    check("pstrb",  64'(pstrb),  wr ? 64'(strb) : 64'd0);
    tick();
    n = 0;
    hold_bad = 1'b0;
    while (psel && penable && n < 100) begin
      if (paddr !== addr || pwrite !== wr || pwdata !== wdata) hold_bad = 1'b1;
      n++;
      tick();
    end
    check("access_cycles", 64'(n), 64'(exp_n));
    check("access_hold",   64'(hold_bad), 64'd0);
    check("resp_psel",  64'(psel),      64'd0);
    check("resp_valid", 64'(rsp_valid), 64'd1);
    if (bp > 0) begin
      // a competing command must be ignored while the response is pending
      cmd_addr  = 32'hFFFF_0000;
      cmd_valid = 1'b1;
      for (int i = 0; i < bp; i++) begin
        check("bp_valid", 64'(rsp_valid), 64'd1);
        check("bp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        check("bp_ready", 64'(cmd_ready), 64'd0);
        check("bp_psel",  64'(psel),      64'd0);
        tick();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    n = 0;
    while (rsp_valid && n < 10) begin
      n++;
      tick();
    end
    check("rsp_drop",   64'(rsp_valid), 64'd0);
    check("back_ready", 64'(cmd_ready), 64'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    check("rst_cmd_ready", 64'(cmd_ready),   64'd1);
    check("rst_psel",      64'(psel),        64'd0);
    check("rst_penable",   64'(penable),     64'd0);
    check("rst_rsp_valid", 64'(rsp_valid),   64'd0);
    check("rst_rsp_err",   64'(rsp_err),     64'd0);
    check("rst_rsp_to",    64'(rsp_timeout), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata),   64'd0);
    check("rst_paddr",     64'(paddr),       64'd0);
    rst_n = 1'b1;
    tick();

    //       wr    addr          wdata          strb  wait hang srd            serr bp n   exp_rd         err  to
    do_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0,  1'b0, 32'h1111_1111, 1'b0, 0, 1,  32'h0,         1'b0, 1'b0);
    do_xfer(1'b0, 32'h0000_0024, 32'h0,         4'hF, 3,  1'b0, 32'h1234_5678, 1'b0, 0, 4,  32'h1234_5678, 1'b0, 1'b0);
    do_xfer(1'b0, 32'h0000_0008, 32'h0,         4'h0, 0,  1'b0, 32'hA5A5_0008, 1'b1, 0, 1,  32'hA5A5_0008, 1'b1, 1'b0);
    do_xfer(1'b0, 32'h0000_0030, 32'h0,         4'h0, 0,  1'b1, 32'h7777_7777, 1'b0, 0, 16, 32'h0,         1'b1, 1'b1);
    do_xfer(1'b1, 32'h0000_0040, 32'h0102_0304, 4'h3, 15, 1'b0, 32'h5555_5555, 1'b0, 0, 16, 32'h0,         1'b0, 1'b0);
    do_xfer(1'b0, 32'h0000_0050, 32'h0,         4'h0, 1,  1'b0, 32'hCAFE_F00D, 1'b0, 5, 2,  32'hCAFE_F00D, 1'b0, 1'b0);
    do_xfer(1'b1, 32'h0000_0054, 32'h0000_00AB, 4'h5, 0,  1'b0, 32'h0,         1'b0, 0, 1,  32'h0,         1'b0, 1'b0);
    do_xfer(1'b1, 32'h0000_0064, 32'h0000_1234, 4'h8, 2,  1'b0, 32'h9999_9999, 1'b1, 0, 3,  32'h0,         1'b1, 1'b0);

    // reset during an ACCESS wait state: transfer dropped, no response
    slv_hang  = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0070;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("mid_penable", 64'(penable), 64'd1);
    rst_n = 1'b0;
    tick();
    check("mrst_psel",      64'(psel),      64'd0);
    check("mrst_penable",   64'(penable),   64'd0);
    check("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_ready", 64'(cmd_ready), 64'd1);
      check("post_rst_valid", 64'(rsp_valid), 64'd0);
    end

    do_xfer(1'b0, 32'h0000_0060, 32'h0,         4'h0, 0,  1'b0, 32'h0BAD_F00D, 1'b0, 0, 1,  32'h0BAD_F00D, 1'b0, 1'b0);

    tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB4 requester (initiator) that converts a simple valid/ready command into APB SETUP/ACCESS phases.
- Returns read data and error status on a valid/ready response channel.
- Sits between a local command source (test sequencer or CPU-side port) and the APB interconnect, driving responders such as the memory slaves.
- Provides an optional ACCESS-phase timeout so that a hung responder cannot lock the bus.

Parameters:
- ADDR_WIDTH, 32: width of cmd_addr and paddr.
- DATA_WIDTH, 32: data width. Must be a multiple of 8.
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles to wait for pready. 0 disables the timeout.
- STRB_WIDTH, DATA_WIDTH/8: computed; width of the byte strobes.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  bridge can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  STRB_WIDTH  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response accepted.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  out  1  pslverr or timeout occurred.
- rsp_timeout  out  1  transfer aborted by the timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  STRB_WIDTH  APB strobes; forced to 0 on reads.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset:
  - rst_n is sampled at posedge clk.
  - State goes to IDLE.
  - All outputs are registered and reset to 0, except cmd_ready, which is 1 when in IDLE.
  - Timeout counter resets to 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1; psel=0; penable=0.
  - On cmd_valid&&cmd_ready: capture cmd_write, cmd_addr, cmd_wdata and cmd_strb (strb captured as 0 if read) into paddr/pwrite/pwdata/pstrb, then go to SETUP.
  - cmd_ready is 0 in every other state.
- SETUP (exactly 1 cycle):
  - psel=1, penable=0.
  - Unconditionally go to ACCESS. Counter clears to 0.
- ACCESS:
  - psel=1, penable=1.
  - paddr/pwrite/pwdata/pstrb are held stable throughout.
- Exit from ACCESS on pready=1:
  - rsp_rdata <= pwrite ? 0 : prdata.
  - rsp_err <= pslverr; rsp_timeout <= 0.
  - psel, penable <= 0; go to RESP.
- While pready=0 in ACCESS:
  - Counter increments.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with pready still 0, the next edge aborts the transfer: psel/penable <= 0; rsp_rdata <= 0; rsp_err <= 1; rsp_timeout <= 1; go to RESP.
  - Net effect: the abort occurs after exactly TIMEOUT_CYCLES ACCESS cycles without pready.
  - pready arriving in the same cycle as the terminal count wins: a normal completion is reported, not a timeout.
- RESP:
  - rsp_valid=1; rsp_* are held stable until rsp_ready=1.
  - On rsp_valid&&rsp_ready: rsp_valid <= 0, go to IDLE.
  - rsp_rdata/rsp_err/rsp_timeout retain their values until the next response is loaded.
- Latency:
  - cmd accept at edge N → psel high at N+1, penable high at N+2.
  - With zero-wait pready, rsp_valid is high from N+3.
  - Minimum issue interval is 4 cycles when rsp_ready is held at 1.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1. It saturates and never wraps.
- pslverr is ignored when pready=0.
- Reset mid-transfer: psel/penable drop at the reset edge, the transfer is discarded, and no response is produced.
- cmd_valid while not in IDLE is ignored and cmd_ready stays 0. The command source must hold its request.

Test Plan:
- Write, zero-wait: cmd_write=1, addr 0x10, wdata 0xDEADBEEF, strb 0xF; pready=1 at ACCESS → psel 1 cycle before penable, pstrb=0xF, rsp_valid at accept+3, rsp_err=0, rsp_rdata=0.
- Read, 3 wait states: addr 0x24; pready low 3 ACCESS cycles then high with prdata 0x12345678 → penable high 4 cycles, paddr stable, rsp_rdata=0x12345678, pstrb=0.
- Slave error: read addr 0x08 with pready=1 and pslverr=1 → rsp_err=1, rsp_timeout=0.
- Timeout, TIMEOUT_CYCLES=16: pready held 0 → penable high exactly 16 cycles, then psel=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Response backpressure: rsp_ready low 5 cycles → rsp_valid and rsp_rdata held stable, cmd_ready=0 throughout; after accept, a second command is taken in IDLE.
- Reset mid-ACCESS: assert rst_n=0 during a wait state → next edge psel=0, penable=0, rsp_valid=0, cmd_ready=1 after release, no response emitted.
